// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/decode/execute/writeback sequencer for the RV32I R-type + RV32M MUL datapath.
module ctrl_fsm #(
   parameter int pcmux_N     = 2,
   parameter int ifuresctl_N = 2,
   parameter int MUL_TIMEOUT = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           run,
   input  logic [6:0]                     opcode,
   input  logic [2:0]                     func3,
   input  logic [1:0]                     func7b50,
   input  logic                           exdone,
   output logic [$clog2(pcmux_N)-1:0]     pcmuxctl,
   output logic                           pcnextctl,
   output logic                           instrre,
   output logic                           regwe,
   output logic                           regre,
   output logic                           mulstart,
   output logic [3:0]                     aluctl,
   output logic [1:0]                     mulctl,
   output logic [$clog2(ifuresctl_N)-1:0] ifuresctl,
   output logic                           illegal,
   output logic                           retire,
   output logic [31:0]                    instret
);
   localparam int IW = $clog2(ifuresctl_N);
   localparam int CW = $clog2(MUL_TIMEOUT);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EX_ALU, EX_MUL, MUL_WAIT, WB, TRAP} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic is_r, alu_ok, mul_ok;
   assign is_r   = opcode == 7'b0110011;
   assign alu_ok = is_r && (func7b50 == 2'b00 || (func7b50 == 2'b10 && (func3 == 3'b000 || func3 == 3'b101)));
   assign mul_ok = is_r && func7b50 == 2'b01 && !func3[2];
   assign pcmuxctl = '0;
   always_comb begin
      state_nx  = state;
      instrre   = 1'b0;
      regre     = 1'b0;
      mulstart  = 1'b0;
      regwe     = 1'b0;
      pcnextctl = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
      case (state)
         IDLE:     state_nx = run ? FETCH : IDLE;
         FETCH: begin
            instrre  = 1'b1;
            state_nx = DECODE;
         end
         DECODE: begin
            regre    = 1'b1;
            state_nx = alu_ok ? EX_ALU : mul_ok ? EX_MUL : TRAP;
         end
         EX_ALU:   state_nx = WB;
         // exdone is deliberately ignored here: the MU may still hold done from the last op
         EX_MUL: begin
            mulstart = 1'b1;
            state_nx = MUL_WAIT;
         end
         MUL_WAIT: state_nx = exdone ? WB : (cnt == CW'(MUL_TIMEOUT - 1)) ? TRAP : MUL_WAIT;
         WB: begin
            regwe     = 1'b1;
            pcnextctl = 1'b1;
            retire    = 1'b1;
            state_nx  = run ? FETCH : IDLE;
         end
         default: begin
            illegal  = 1'b1;
            state_nx = TRAP;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         aluctl    <= '0;
         mulctl    <= '0;
         ifuresctl <= '0;
         instret   <= '0;
      end else begin
         state <= state_nx;
         if (state == DECODE) begin
            aluctl    <= {func7b50[1], func3};
            mulctl    <= func3[1:0];
            ifuresctl <= IW'(mul_ok);
         end
         if (state == EX_MUL) cnt <= '0;
         else if (state == MUL_WAIT && state_nx == MUL_WAIT) cnt <= cnt + 1'b1;
         // counted on WB entry so the count already includes the retiring instruction
         if (state_nx == WB) instret <= instret + 32'd1;
      end
   end
endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
- Multi-cycle control unit sitting on the control side of the integer datapath.
- Consumes the datapath's decode fields (opcode, func3, func7b50) and EX-stage done flag (exdone).
- Sequences fetch → decode → execute → writeback by driving every datapath enable and select.
- Supports RV32I R-type ALU ops and RV32M MUL/MULH/MULHSU/MULHU. All other encodings trap.

Parameters:
- pcmux_N, 2, number of pc mux inputs; pcmuxctl width = $clog2(pcmux_N).
- ifuresctl_N, 2, number of IFU result mux inputs; ifuresctl width = $clog2(ifuresctl_N).
- MUL_TIMEOUT, 64, maximum cycles spent in MUL_WAIT before trapping; must be ≥ 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; enables leaving IDLE to start fetching.
- opcode  in  7  instr[6:0] from datapath.
- func3  in  3  instr[14:12].
- func7b50  in  2  {instr[30], instr[25]}.
- exdone  in  1  EX-stage done from datapath.
- pcmuxctl  out  $clog2(pcmux_N)  pc mux select; always 0 (pc+4).
- pcnextctl  out  1  pc update strobe.
- instrre  out  1  instruction memory read enable.
- regwe  out  1  register file write enable.
- regre  out  1  register file read enable.
- mulstart  out  1  MU start pulse.
- aluctl  out  4  ALU op.
- mulctl  out  2  MU op.
- ifuresctl  out  $clog2(ifuresctl_N)  IFU result select; 0 = ALU, 1 = MU.
- illegal  out  1  sticky trap flag.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  32  retired-instruction counter.

Behaviour:
- Reset (rst=0, async):
  - state = IDLE.
  - All outputs 0, including aluctl, mulctl, ifuresctl, instret, and the timeout counter.
- State outputs (strobes are 0 unless listed for that state):
  - IDLE: no strobes. If run=1, next state is FETCH.
  - FETCH: instrre=1. Next state is DECODE. The clocked imem presents instr during DECODE.
  - DECODE: regre=1. Decode and register aluctl, mulctl, ifuresctl at the exit edge. Transitions:
    - opcode=0110011 and func7b50=00 (func3 any) → EX_ALU.
    - opcode=0110011 and func7b50=10 and func3 ∈ {000, 101} (SUB/SRA) → EX_ALU.
    - opcode=0110011 and func7b50=01 and func3[2]=0 → EX_MUL.
    - Anything else, including DIV/REM (func7b50=01, func3[2]=1) → TRAP.
  - EX_ALU: ifuresctl=0. Next state is WB unconditionally (ALU is combinational).
  - EX_MUL: mulstart=1 (exactly one cycle), ifuresctl=1. Timeout counter cleared. Next state is MUL_WAIT. exdone is ignored in this cycle, since a stale mudone may still be high.
  - MUL_WAIT: mulstart=0. ifuresctl and mulctl held.
    - exdone=1 → WB.
    - Otherwise the counter increments.
    - Counter reaching MUL_TIMEOUT-1 without exdone → TRAP.
  - WB: regwe=1, pcnextctl=1, retire=1, instret += 1 (wraps at 2^32). aluctl, mulctl, ifuresctl held from DECODE. Next state: FETCH if run=1, else IDLE.
  - TRAP: illegal=1, all strobes 0, instret frozen. Exits only on reset.
- Decode encodings:
  - aluctl = {func7b50[1], func3} for ALU ops. Examples: ADD=0000, SUB=1000, SRA=1101.
  - mulctl = func3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- Timing:
  - aluctl, mulctl and ifuresctl are registered and stable from EX entry through the WB cycle.
  - Latency per instruction:
    - ALU: 4 cycles (FETCH, DECODE, EX_ALU, WB).
    - MUL: 4 + k cycles, where k = MUL_WAIT cycles (≥1).
- Boundary conditions:
  - run deasserted mid-instruction: the current instruction completes through WB, then the FSM parks in IDLE.
  - Reset asserted in any state, including mid-MUL: immediate return to IDLE with outputs cleared. No partial writeback strobe.
  - At most one of instrre, regre, mulstart, regwe is high in any cycle (one-hot strobes).

Test Plan:
- Reset with run=0, then hold: all outputs 0, FSM stays IDLE, no strobes for 10 cycles.
- run=1, ADD (opcode 0110011, func3 000, func7b50 00): instrre at cycle 1, regre at 2, WB at 4 with aluctl=0000, ifuresctl=0, regwe=pcnextctl=retire=1, instret=1.
- SRA (func3 101, func7b50 10) back-to-back with SUB: aluctl=1101 then 1000; instret=2 after 8 cycles.
- MULHU (func7b50 01, func3 011), exdone low 5 cycles then high:
  - mulstart is a single pulse and mulctl=11, ifuresctl=1 through WB.
  - regwe fires the cycle after exdone.
- DIV (func7b50 01, func3 100), or opcode 0010011: TRAP, illegal=1, no regwe/pcnextctl; illegal persists until rst=0.
- MUL with exdone never asserted and MUL_TIMEOUT=8: TRAP after 8 MUL_WAIT cycles. Separately, rst pulsed low mid-MUL_WAIT: outputs 0 immediately, instret=0.
